// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into instruction memory
// one 32-bit big-endian word at a time, holding the core in reset while it loads.
module imem_loader #(
  parameter int WORDS = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(WORDS);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    len_hi;
  logic [15:0]   len_in;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   partial;
  logic [7:0]    csum;
  logic          accept;
  logic          busy_nxt;

  assign accept = byte_ready && byte_valid;
  assign len_in = {len_hi, byte_data};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR:
        if (start) state_nxt = ST_LEN_HI;
      ST_LEN_HI:
        if (accept) state_nxt = ST_LEN_LO;
      ST_LEN_LO:
        if (accept) begin
          if ((len_in != 16'd0) && ({1'b0, len_in} <= MAX_LEN)) state_nxt = ST_DATA;
          else state_nxt = ST_ERR;
        end
      ST_DATA:
        if (accept && (byte_idx == 2'd3) && (word_idx == last_idx)) state_nxt = ST_CSUM;
      ST_CSUM:
        if (accept) state_nxt = (byte_data == csum) ? ST_DONE : ST_ERR;
      default:
        state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt == ST_LEN_HI) || (state_nxt == ST_LEN_LO) ||
               (state_nxt == ST_DATA)   || (state_nxt == ST_CSUM);
  end

  // Status outputs are registered from the next state so they always match the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      core_hold  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      len_hi     <= '0;
      last_idx   <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      partial    <= '0;
      csum       <= '0;
    end else begin
      state      <= state_nxt;
      byte_ready <= busy_nxt;
      busy       <= busy_nxt;
      core_hold  <= busy_nxt || (state_nxt == ST_ERR);
      done       <= (state_nxt == ST_DONE);
      err        <= (state_nxt == ST_ERR);
      wr_en      <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR:
          if (start) begin
            word_idx <= '0;
            byte_idx <= '0;
            partial  <= '0;
            csum     <= '0;
          end
        ST_LEN_HI:
          if (accept) begin
            len_hi <= byte_data;
            csum   <= csum ^ byte_data;
          end
        ST_LEN_LO:
          if (accept) begin
            last_idx <= AW'(len_in - 16'd1);
            csum     <= csum ^ byte_data;
          end
        ST_DATA:
          if (accept) begin
            csum     <= csum ^ byte_data;
            partial  <= {partial[15:0], byte_data};
            byte_idx <= byte_idx + 2'd1;
            // Fourth byte completes the word: write it straight from the shift register.
            if (byte_idx == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= word_idx;
              wr_data  <= {partial, byte_data};
              word_idx <= word_idx + AW'(1);
            end
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads
// checked against a stream-level model of the expected writes and final status.
module tb_imem_loader;

  localparam int WORDS = 128;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]    stim[$];
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];

  imem_loader #(.WORDS(WORDS), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Capture every write the loader issues so whole loads can be compared to the model.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    @(negedge clk);
  endtask

  // Offers one byte from a falling edge; returns at the falling edge after it was accepted.
  task automatic apply_stimulus(input logic [7:0] b, output bit ok, output int waited);
    ok         = 1'b0;
    waited     = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!ok && waited < 50) begin
      if (byte_ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
        waited++;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, ":byte_ready"}, byte_ready, 0);
    check_output({name, ":wr_en"},      wr_en,      0);
    check_output({name, ":wr_addr"},    wr_addr,    0);
    check_output({name, ":wr_data"},    wr_data,    0);
    check_output({name, ":core_hold"},  core_hold,  0);
    check_output({name, ":busy"},       busy,       0);
    check_output({name, ":done"},       done,       0);
    check_output({name, ":err"},        err,        0);
  endtask

  // Runs the whole stream in stim and checks it against what the stream format implies.
  task automatic run_load(input int gap_pct, input int mid_start, input string name);
    int          n;
    bit          bad_len;
    int          n_bytes;
    logic [7:0]  x;
    bit          exp_ok;
    logic [31:0] exp_data[$];
    bit          ok;
    int          waited;
    int          d;
    bit          wexp;
    n       = int'({stim[0], stim[1]});
    bad_len = (n == 0) || (n > WORDS);
    n_bytes = bad_len ? 2 : 3 + 4 * n;
    x = 8'h00;
    for (int i = 0; i < (bad_len ? 2 : 2 + 4 * n); i++) x ^= stim[i];
    if (!bad_len)
      for (int k = 0; k < n; k++)
        exp_data.push_back({stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]});
    exp_ok = !bad_len && (stim[n_bytes-1] == x);
    got_addr.delete();
    got_data.delete();

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output({name, ":start_busy"},  busy,       1);
    check_output({name, ":start_ready"}, byte_ready, 1);
    check_output({name, ":start_hold"},  core_hold,  1);
    check_output({name, ":start_done"},  done,       0);
    check_output({name, ":start_err"},   err,        0);

    for (int i = 0; i < n_bytes; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle_cycle();
      if (i == mid_start) start = 1'b1;
      apply_stimulus(stim[i], ok, waited);
      start = 1'b0;
      check_output({name, ":accept"}, ok, 1);
      check_output({name, ":stall"},  waited, 0);
      if (!bad_len && i >= 2 && i < n_bytes - 1) begin
        d    = i - 2;
        wexp = (d % 4 == 3);
        check_output({name, ":wr_en"}, wr_en, wexp);
        if (wexp) begin
          check_output({name, ":wr_addr"}, wr_addr, d / 4);
          check_output({name, ":wr_data"}, wr_data, exp_data[d/4]);
        end
      end
    end

    check_output({name, ":end_done"},  done,       exp_ok);
    check_output({name, ":end_err"},   err,        !exp_ok);
    check_output({name, ":end_hold"},  core_hold,  !exp_ok);
    check_output({name, ":end_busy"},  busy,       0);
    check_output({name, ":end_ready"}, byte_ready, 0);
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check_output({name, ":stay_done"}, done, exp_ok);
    check_output({name, ":n_writes"}, got_addr.size(), exp_data.size());
    for (int k = 0; k < got_addr.size() && k < exp_data.size(); k++) begin
      check_output({name, ":log_addr"}, got_addr[k], k);
      check_output({name, ":log_data"}, got_data[k], exp_data[k]);
    end
    if (!bad_len) begin
      check_output({name, ":hold_addr"}, wr_addr, n - 1);
      check_output({name, ":hold_data"}, wr_data, exp_data[n-1]);
    end
  endtask

  task automatic load_basic(input logic [7:0] csum_byte);
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    stim.push_back(csum_byte);
  endtask

  task automatic load_random(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    x = stim[0] ^ stim[1];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      x ^= b;
    end
    if (good) stim.push_back(x);
    else stim.push_back(x ^ 8'($urandom_range(1, 255)));
  endtask

  initial begin
    bit ok;
    int waited;
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load_basic(8'h02);
    run_load(0, -1, "basic");
    load_basic(8'h03);
    run_load(0, -1, "bad_csum");
    stim = '{8'h00, 8'h81};
    run_load(0, -1, "len_129");
    stim = '{8'h00, 8'h00};
    run_load(0, -1, "len_0");
    load_basic(8'h02);
    run_load(100, -1, "gappy");
    load_basic(8'h02);
    run_load(0, 6, "mid_start");

    // Reset in the middle of the second word must drop the partial word.
    load_basic(8'h02);
    got_addr.delete();
    got_data.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(stim[i], ok, waited);
      check_output("rst_mid:accept", ok, 1);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      check_output("post_rst:ready", byte_ready, 0);
      check_output("post_rst:busy",  busy,       0);
    end
    byte_valid = 1'b0;
    check_output("rst_mid:n_writes", got_addr.size(), 1);
    if (got_addr.size() >= 1) begin
      check_output("rst_mid:addr", got_addr[0], 0);
      check_output("rst_mid:data", got_data[0], 32'h12345678);
    end
    load_basic(8'h02);
    run_load(0, -1, "after_rst");

    load_random(WORDS, 1'b1);
    run_load(0, -1, "full_depth");
    n = $urandom_range(WORDS + 1, 65535);
    stim = '{8'(n >> 8), 8'(n)};
    run_load(0, -1, "len_big");

    for (int t = 0; t < 8; t++) begin
      load_random($urandom_range(1, 6), $urandom_range(0, 3) != 0);
      run_load((t % 2 == 1) ? 40 : 0, -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
